// File: rtl/rv32im_pkg.sv
// Shared definitions for the rv32im interrupt controller slice.
//   - Wishbone register word indices
//   - Controller FSM state encoding
//   - Vector table shift (index -> byte offset)
package rv32im_pkg;

  localparam logic [1:0] RegEnable  = 2'd0;
  localparam logic [1:0] RegPending = 2'd1;
  localparam logic [1:0] RegStatus  = 2'd2;

  // Vector table entries are one 32-bit word each.
  localparam int unsigned VecShift = 2;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StTrigger   = 2'd1,
    StInService = 2'd2
  } state_e;

endpackage

// File: rtl/rv32im_priority_encoder.sv
// Lowest-set-bit priority encoder (combinational).
//   req_i   : request vector
//   valid_o : any request set
//   index_o : index of the lowest set request bit (0 when none)
module rv32im_priority_encoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_o,
  output logic [4:0]       index_o
);

  always_comb begin
    valid_o = |req_i;
    index_o = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        index_o = 5'(i);
      end
    end
  end

endmodule

// File: rtl/rv32im_interrupt_controller.sv
// Prioritised, rising-edge interrupt controller feeding the rv32im_no_pipe core.
//   clk_i, reset_i                   : clock, async active-high reset
//   irq_i                            : interrupt sources (rising-edge sensitive)
//   interrupt_vector_offset_o        : byte offset of the serviced vector (index*4)
//   interrupt_trigger_o              : one-cycle request pulse to the core
//   interrupt_routine_complete_i     : core's mret completion pulse
//   dat_i/dat_o/adr_i/cyc_i/stb_i/we_i/sel_i/ack_o : Wishbone slave
//     word 0 ENABLE (RW), 1 PENDING (R, W1C), 2 STATUS (RO), 3 reads zero
module rv32im_interrupt_controller
  import rv32im_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned INT_VECT_LEN = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [INT_VECT_LEN-1:0] irq_i,
  output logic [XLEN-1:0]         interrupt_vector_offset_o,
  output logic                    interrupt_trigger_o,
  input  logic                    interrupt_routine_complete_i,
  input  logic [XLEN-1:0]         dat_i,
  output logic [XLEN-1:0]         dat_o,
  input  logic [1:0]              adr_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [3:0]              sel_i,
  output logic                    ack_o
);

  state_e                  state_q, state_d;
  logic [INT_VECT_LEN-1:0] irq_q;
  logic [INT_VECT_LEN-1:0] enable_q, enable_d;
  logic [INT_VECT_LEN-1:0] pending_q, pending_d;
  logic [4:0]              active_idx_q, active_idx_d;
  logic [XLEN-1:0]         vec_off_q, vec_off_d;
  logic                    ack_q;
  logic [XLEN-1:0]         dat_q, rdata;

  logic [INT_VECT_LEN-1:0] irq_edge;
  logic [INT_VECT_LEN-1:0] grant_clr;
  logic [INT_VECT_LEN-1:0] w1c;
  logic [INT_VECT_LEN-1:0] wmask;
  logic [INT_VECT_LEN-1:0] wbits;
  logic                    win_valid;
  logic [4:0]              win_idx;
  logic                    bus_req;
  logic                    bus_wr;
  logic                    unused_bus;

  assign irq_edge = irq_i & ~irq_q;

  // A new request is only accepted while no ack is outstanding.
  assign bus_req = cyc_i & stb_i & ~ack_q;
  assign bus_wr  = bus_req & we_i;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < int'(INT_VECT_LEN); i++) begin
      wmask[i] = sel_i[i / 8];
    end
  end

  assign wbits      = dat_i[INT_VECT_LEN-1:0] & wmask;
  assign unused_bus = ^{dat_i, sel_i};

  rv32im_priority_encoder #(
    .WIDTH (INT_VECT_LEN)
  ) u_prio (
    .req_i   (pending_q & enable_q),
    .valid_o (win_valid),
    .index_o (win_idx)
  );

  // Controller FSM next state.
  always_comb begin
    state_d      = state_q;
    active_idx_d = active_idx_q;
    vec_off_d    = vec_off_q;
    grant_clr    = '0;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d      = StTrigger;
          active_idx_d = win_idx;
          vec_off_d    = XLEN'(win_idx) << VecShift;
          grant_clr    = INT_VECT_LEN'(1) << win_idx;
        end
      end
      StTrigger: state_d = StInService;
      StInService: begin
        if (interrupt_routine_complete_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Register updates; new edges are OR-ed in last so a set beats any clear.
  always_comb begin
    w1c      = (bus_wr && adr_i == RegPending) ? wbits : '0;
    enable_d = enable_q;
    if (bus_wr && adr_i == RegEnable) begin
      enable_d = (enable_q & ~wmask) | wbits;
    end
    pending_d = (pending_q & ~grant_clr & ~w1c) | irq_edge;
  end

  always_comb begin
    rdata = '0;
    unique case (adr_i)
      RegEnable:  rdata[INT_VECT_LEN-1:0] = enable_q;
      RegPending: rdata[INT_VECT_LEN-1:0] = pending_q;
      RegStatus: begin
        rdata[XLEN-1] = (state_q != StIdle);
        rdata[4:0]    = active_idx_q;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      irq_q        <= '0;
      enable_q     <= '0;
      pending_q    <= '0;
      active_idx_q <= '0;
      vec_off_q    <= '0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_i;
      enable_q     <= enable_d;
      pending_q    <= pending_d;
      active_idx_q <= active_idx_d;
      vec_off_q    <= vec_off_d;
      ack_q        <= bus_req;
      dat_q        <= bus_req ? rdata : '0;
    end
  end

  // Decoded from state so reset drops the pulse immediately.
  assign interrupt_trigger_o       = (state_q == StTrigger);
  assign interrupt_vector_offset_o = vec_off_q;
  assign ack_o                     = ack_q;
  assign dat_o                     = dat_q;

endmodule
